// File: rtl/ysyx_24100029_axi_arbiter.sv
// Two-master, one-slave AXI4 arbiter: IFU (M0, read) and LSU (M1, read/write).
// Whole-transaction grants with round-robin and a sticky hung-slave watchdog.
module ysyx_24100029_axi_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic [ID_W-1:0]   m0_rid,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic [ID_W-1:0]   m1_rid,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic [ID_W-1:0]   m1_awid,
  input  logic [7:0]        m1_awlen,
  input  logic [2:0]        m1_awsize,
  input  logic [1:0]        m1_awburst,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic              m1_wlast,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  output logic [1:0]        m1_bresp,
  output logic [ID_W-1:0]   m1_bid,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [ID_W-1:0]   s_arid,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic [ID_W-1:0]   s_rid,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic [ID_W-1:0]   s_awid,
  output logic [7:0]        s_awlen,
  output logic [2:0]        s_awsize,
  output logic [1:0]        s_awburst,
  output logic              s_wvalid,
  input  logic              s_wready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic              s_wlast,
  input  logic              s_bvalid,
  output logic              s_bready,
  input  logic [1:0]        s_bresp,
  input  logic [ID_W-1:0]   s_bid,
  output logic [1:0]        grant,
  output logic              err
);

  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    M0_RD = 2'd1,
    M1_RD = 2'd2,
    M1_WR = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;
  logic          req0, req1;

  assign req0 = m0_arvalid;
  assign req1 = m1_arvalid | m1_awvalid;

  // Response payloads are broadcast; only the valids are gated by ownership.
  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m0_rlast = s_rlast;
  assign m0_rid   = s_rid;
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign m1_rlast = s_rlast;
  assign m1_rid   = s_rid;
  assign m1_bresp = s_bresp;
  assign m1_bid   = s_bid;
  assign err      = err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant      = 2'b00;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_arid     = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_arburst  = '0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_awid     = '0;
    s_awlen    = '0;
    s_awsize   = '0;
    s_awburst  = '0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wlast    = 1'b0;
    s_bready   = 1'b0;
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // last_q=1 means M1 went last, so M0 wins a tie.
        if (req0 && (!req1 || last_q)) begin
          state_d = M0_RD;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = m1_awvalid ? M1_WR : M1_RD;
          last_d  = 1'b1;
        end
      end
      M0_RD: begin
        grant      = 2'b01;
        s_arvalid  = m0_arvalid;
        s_araddr   = m0_araddr;
        s_arid     = m0_arid;
        s_arlen    = m0_arlen;
        s_arsize   = m0_arsize;
        s_arburst  = m0_arburst;
        m0_arready = s_arready;
        m0_rvalid  = s_rvalid;
        s_rready   = m0_rready;
        if (s_rvalid && m0_rready && s_rlast)
          state_d = IDLE;
      end
      M1_RD: begin
        grant      = 2'b10;
        s_arvalid  = m1_arvalid;
        s_araddr   = m1_araddr;
        s_arid     = m1_arid;
        s_arlen    = m1_arlen;
        s_arsize   = m1_arsize;
        s_arburst  = m1_arburst;
        m1_arready = s_arready;
        m1_rvalid  = s_rvalid;
        s_rready   = m1_rready;
        if (s_rvalid && m1_rready && s_rlast)
          state_d = IDLE;
      end
      M1_WR: begin
        grant      = 2'b10;
        s_awvalid  = m1_awvalid;
        s_awaddr   = m1_awaddr;
        s_awid     = m1_awid;
        s_awlen    = m1_awlen;
        s_awsize   = m1_awsize;
        s_awburst  = m1_awburst;
        m1_awready = s_awready;
        s_wvalid   = m1_wvalid;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wlast    = m1_wlast;
        m1_wready  = s_wready;
        m1_bvalid  = s_bvalid;
        s_bready   = m1_bready;
        if (s_bvalid && m1_bready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // wdog_q equals the number of owned cycles, including the current one.
  always_comb begin
    wdog_d = '0;
    err_d  = err_q;
    if (state_d != IDLE) begin
      wdog_d = (wdog_q == TMO) ? wdog_q : wdog_q + 1'b1;
      if ((TIMEOUT != 0) && (wdog_d == TMO))
        err_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_24100029_axi_arbiter.sv
// Directed bench for the AXI arbiter: grants, routing, round-robin,
// write stalls, error responses and the watchdog (TIMEOUT=8).
module tb_ysyx_24100029_axi_arbiter;

  logic        clock, reset;
  logic        m0_arvalid, m0_arready;
  logic [31:0] m0_araddr;
  logic [3:0]  m0_arid;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [1:0]  m0_arburst;
  logic        m0_rvalid, m0_rready;
  logic [31:0] m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m0_rlast;
  logic [3:0]  m0_rid;
  logic        m1_arvalid, m1_arready;
  logic [31:0] m1_araddr;
  logic [3:0]  m1_arid;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic [1:0]  m1_arburst;
  logic        m1_rvalid, m1_rready;
  logic [31:0] m1_rdata;
  logic [1:0]  m1_rresp;
  logic        m1_rlast;
  logic [3:0]  m1_rid;
  logic        m1_awvalid, m1_awready;
  logic [31:0] m1_awaddr;
  logic [3:0]  m1_awid;
  logic [7:0]  m1_awlen;
  logic [2:0]  m1_awsize;
  logic [1:0]  m1_awburst;
  logic        m1_wvalid, m1_wready;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_wlast;
  logic        m1_bvalid, m1_bready;
  logic [1:0]  m1_bresp;
  logic [3:0]  m1_bid;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic [3:0]  s_arid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [3:0]  s_rid;
  logic        s_awvalid, s_awready;
  logic [31:0] s_awaddr;
  logic [3:0]  s_awid;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast;
  logic        s_bvalid, s_bready;
  logic [1:0]  s_bresp;
  logic [3:0]  s_bid;
  logic [1:0]  grant;
  logic        err;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  ysyx_24100029_axi_arbiter #(
    .ADDR_W(32), .DATA_W(32), .ID_W(4), .TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
    .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rid(m0_rid),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
    .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rid(m1_rid),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
    .m1_awid(m1_awid), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
    .m1_awburst(m1_awburst),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .m1_bid(m1_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_bid(s_bid),
    .grant(grant), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clear_inputs();
    m0_arvalid = 0; m0_araddr = '0; m0_arid = '0; m0_arlen = '0;
    m0_arsize = 3'd2; m0_arburst = 2'b01; m0_rready = 0;
    m1_arvalid = 0; m1_araddr = '0; m1_arid = '0; m1_arlen = '0;
    m1_arsize = 3'd2; m1_arburst = 2'b01; m1_rready = 0;
    m1_awvalid = 0; m1_awaddr = '0; m1_awid = '0; m1_awlen = '0;
    m1_awsize = 3'd2; m1_awburst = 2'b01;
    m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 0;
    m1_bready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
    s_rlast = 0; s_rid = '0; s_awready = 0; s_wready = 0;
    s_bvalid = 0; s_bresp = '0; s_bid = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    repeat (2) @(negedge clock);
    reset = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    #1;
    tot_cnt++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", grant); else pass_cnt++;
    tot_cnt++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else pass_cnt++;
    tot_cnt++; if ({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready} !== 5'b0) $display("FAIL rst_s_valid: got %b want 00000", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}); else pass_cnt++;
    tot_cnt++; if ({m0_arready, m1_arready, m1_awready, m1_wready, m0_rvalid, m1_rvalid, m1_bvalid} !== 7'b0) $display("FAIL rst_m_hs: got %b want 0000000", {m0_arready, m1_arready, m1_awready, m1_wready, m0_rvalid, m1_rvalid, m1_bvalid}); else pass_cnt++;
    repeat (2) @(negedge clock);
    reset = 1;
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clock);
    m0_arvalid = 1; m0_araddr = 32'h2000_0000; m0_arid = 4'h3; m0_rready = 1;
    #1;
    tot_cnt++; if (grant !== 2'b00) $display("FAIL sr_idle_grant: got %b want 00", grant); else pass_cnt++;
    tot_cnt++; if (s_arvalid !== 1'b0) $display("FAIL sr_idle_arvalid: got %b want 0", s_arvalid); else pass_cnt++;
    @(negedge clock); #1;
    tot_cnt++; if (grant !== 2'b01) $display("FAIL sr_grant: got %b want 01", grant); else pass_cnt++;
    tot_cnt++; if (s_arvalid !== 1'b1) $display("FAIL sr_s_arvalid: got %b want 1", s_arvalid); else pass_cnt++;
    tot_cnt++; if (s_araddr !== 32'h2000_0000) $display("FAIL sr_araddr: got %h want 20000000", s_araddr); else pass_cnt++;
    s_arready = 1; #1;
    tot_cnt++; if (m0_arready !== 1'b1) $display("FAIL sr_arready: got %b want 1", m0_arready); else pass_cnt++;
    @(negedge clock);
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'h0000_0413; s_rlast = 1; s_rid = 4'h3;
    #1;
    tot_cnt++; if (m0_rvalid !== 1'b1) $display("FAIL sr_rvalid: got %b want 1", m0_rvalid); else pass_cnt++;
    tot_cnt++; if (m0_rdata !== 32'h0000_0413) $display("FAIL sr_rdata: got %h want 00000413", m0_rdata); else pass_cnt++;
    tot_cnt++; if (s_rready !== 1'b1) $display("FAIL sr_s_rready: got %b want 1", s_rready); else pass_cnt++;
    tot_cnt++; if (m0_rid !== 4'h3) $display("FAIL sr_rid: got %h want 3", m0_rid); else pass_cnt++;
    @(negedge clock);
    s_rvalid = 0; s_rlast = 0;
    #1;
    tot_cnt++; if (grant !== 2'b00) $display("FAIL sr_done_grant: got %b want 00", grant); else pass_cnt++;
    tot_cnt++; if (err !== 1'b0) $display("FAIL sr_err: got %b want 0", err); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    do_reset();
    @(negedge clock);
    m0_arvalid = 1; m0_araddr = 32'h2000_0040; m0_rready = 1;
    m1_arvalid = 1; m1_araddr = 32'h3000_0000; m1_rready = 1;
    @(negedge clock); #1;
    tot_cnt++; if (grant !== 2'b01) $display("FAIL rr_first_grant: got %b want 01", grant); else pass_cnt++;
    tot_cnt++; if (s_araddr !== 32'h2000_0040) $display("FAIL rr_m0_addr: got %h want 20000040", s_araddr); else pass_cnt++;
    s_arready = 1; #1;
    tot_cnt++; if (m1_arready !== 1'b0) $display("FAIL rr_m1_arready_held: got %b want 0", m1_arready); else pass_cnt++;
    tot_cnt++; if (m0_arready !== 1'b1) $display("FAIL rr_m0_arready: got %b want 1", m0_arready); else pass_cnt++;
    @(negedge clock);
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rlast = 1; s_rdata = 32'h1111_2222;
    #1;
    tot_cnt++; if (m1_rvalid !== 1'b0) $display("FAIL rr_m1_rvalid_gated: got %b want 0", m1_rvalid); else pass_cnt++;
    tot_cnt++; if (m0_rvalid !== 1'b1) $display("FAIL rr_m0_rvalid: got %b want 1", m0_rvalid); else pass_cnt++;
    @(negedge clock);
    s_rvalid = 0; s_rlast = 0;
    #1;
    tot_cnt++; if (grant !== 2'b00) $display("FAIL rr_gap_grant: got %b want 00", grant); else pass_cnt++;
    @(negedge clock); #1;
    tot_cnt++; if (grant !== 2'b10) $display("FAIL rr_second_grant: got %b want 10", grant); else pass_cnt++;
    tot_cnt++; if (s_araddr !== 32'h3000_0000) $display("FAIL rr_m1_addr: got %h want 30000000", s_araddr); else pass_cnt++;
    s_arready = 1; #1;
    tot_cnt++; if (m1_arready !== 1'b1) $display("FAIL rr_m1_arready: got %b want 1", m1_arready); else pass_cnt++;
    @(negedge clock);
    m1_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rlast = 1;
    #1;
    tot_cnt++; if ({m1_rvalid, m0_rvalid} !== 2'b10) $display("FAIL rr_m1_r_route: got %b want 10", {m1_rvalid, m0_rvalid}); else pass_cnt++;
    @(negedge clock);
    s_rvalid = 0; s_rlast = 0;
    #1;
    tot_cnt++; if (grant !== 2'b00) $display("FAIL rr_end_grant: got %b want 00", grant); else pass_cnt++;
  endtask

  task automatic test_write_stall();
    do_reset();
    @(negedge clock);
    m1_awvalid = 1; m1_awaddr = 32'h8000_0010; m1_awid = 4'h5;
    m1_wvalid = 1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF; m1_wlast = 1;
    m1_bready = 1;
    #1;
    tot_cnt++; if (m1_wready !== 1'b0) $display("FAIL wr_pre_wready: got %b want 0", m1_wready); else pass_cnt++;
    tot_cnt++; if (s_wvalid !== 1'b0) $display("FAIL wr_pre_s_wvalid: got %b want 0", s_wvalid); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      tot_cnt++; if ({grant, s_awvalid, m1_awready} !== 4'b1010) $display("FAIL wr_aw_stall%0d: got %b want 1010", i, {grant, s_awvalid, m1_awready}); else pass_cnt++;
    end
    s_awready = 1; s_wready = 1;
    #1;
    tot_cnt++; if ({m1_awready, m1_wready} !== 2'b11) $display("FAIL wr_readies: got %b want 11", {m1_awready, m1_wready}); else pass_cnt++;
    tot_cnt++; if (s_awaddr !== 32'h8000_0010) $display("FAIL wr_awaddr: got %h want 80000010", s_awaddr); else pass_cnt++;
    tot_cnt++; if (s_wdata !== 32'hDEAD_BEEF) $display("FAIL wr_wdata: got %h want deadbeef", s_wdata); else pass_cnt++;
    tot_cnt++; if (s_wstrb !== 4'hF) $display("FAIL wr_wstrb: got %h want f", s_wstrb); else pass_cnt++;
    @(negedge clock);
    m1_awvalid = 0; m1_wvalid = 0; s_awready = 0; s_wready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tot_cnt++; if ({grant, m1_bvalid} !== 3'b100) $display("FAIL wr_b_wait%0d: got %b want 100", i, {grant, m1_bvalid}); else pass_cnt++;
      @(negedge clock);
    end
    s_bvalid = 1; s_bresp = 2'b00; s_bid = 4'h5;
    #1;
    tot_cnt++; if ({m1_bvalid, s_bready} !== 2'b11) $display("FAIL wr_b_hs: got %b want 11", {m1_bvalid, s_bready}); else pass_cnt++;
    tot_cnt++; if (m1_bresp !== 2'b00) $display("FAIL wr_bresp: got %b want 00", m1_bresp); else pass_cnt++;
    tot_cnt++; if (m1_bid !== 4'h5) $display("FAIL wr_bid: got %h want 5", m1_bid); else pass_cnt++;
    @(negedge clock);
    s_bvalid = 0;
    #1;
    tot_cnt++; if (grant !== 2'b00) $display("FAIL wr_end_grant: got %b want 00", grant); else pass_cnt++;
  endtask

  task automatic test_wr_then_rd();
    do_reset();
    @(negedge clock);
    m1_awvalid = 1; m1_awaddr = 32'h0000_0100;
    m1_arvalid = 1; m1_araddr = 32'h0000_0200;
    m1_wvalid = 1; m1_wlast = 1; m1_wstrb = 4'h3;
    m1_bready = 1; m1_rready = 1;
    @(negedge clock); #1;
    tot_cnt++; if (grant !== 2'b10) $display("FAIL wrd_grant_wr: got %b want 10", grant); else pass_cnt++;
    tot_cnt++; if ({s_awvalid, s_arvalid, m1_arready} !== 3'b100) $display("FAIL wrd_wr_first: got %b want 100", {s_awvalid, s_arvalid, m1_arready}); else pass_cnt++;
    s_awready = 1; s_wready = 1;
    @(negedge clock);
    m1_awvalid = 0; m1_wvalid = 0; s_awready = 0; s_wready = 0;
    s_bvalid = 1;
    #1;
    tot_cnt++; if (m1_bvalid !== 1'b1) $display("FAIL wrd_bvalid: got %b want 1", m1_bvalid); else pass_cnt++;
    @(negedge clock);
    s_bvalid = 0;
    #1;
    tot_cnt++; if (grant !== 2'b00) $display("FAIL wrd_gap_grant: got %b want 00", grant); else pass_cnt++;
    @(negedge clock); #1;
    tot_cnt++; if ({grant, s_arvalid, s_awvalid} !== 4'b1010) $display("FAIL wrd_rd_route: got %b want 1010", {grant, s_arvalid, s_awvalid}); else pass_cnt++;
    tot_cnt++; if (s_araddr !== 32'h0000_0200) $display("FAIL wrd_araddr: got %h want 00000200", s_araddr); else pass_cnt++;
    s_arready = 1;
    @(negedge clock);
    m1_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rlast = 1;
    #1;
    tot_cnt++; if (m1_rvalid !== 1'b1) $display("FAIL wrd_rvalid: got %b want 1", m1_rvalid); else pass_cnt++;
    @(negedge clock);
    s_rvalid = 0; s_rlast = 0;
    #1;
    tot_cnt++; if (grant !== 2'b00) $display("FAIL wrd_end_grant: got %b want 00", grant); else pass_cnt++;
  endtask

  task automatic test_slverr();
    do_reset();
    @(negedge clock);
    m0_arvalid = 1; m0_araddr = 32'h2000_0100; m0_rready = 1; m1_rready = 1;
    @(negedge clock);
    s_arready = 1;
    @(negedge clock);
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rlast = 1; s_rresp = 2'b10;
    #1;
    tot_cnt++; if (m0_rresp !== 2'b10) $display("FAIL se_rresp: got %b want 10", m0_rresp); else pass_cnt++;
    tot_cnt++; if (m0_rvalid !== 1'b1) $display("FAIL se_rvalid: got %b want 1", m0_rvalid); else pass_cnt++;
    @(negedge clock);
    s_rvalid = 0; s_rlast = 0; s_rresp = 2'b00;
    m0_arvalid = 1; m1_arvalid = 1; m1_araddr = 32'h3000_0040;
    #1;
    tot_cnt++; if (grant !== 2'b00) $display("FAIL se_idle_grant: got %b want 00", grant); else pass_cnt++;
    @(negedge clock); #1;
    tot_cnt++; if (grant !== 2'b10) $display("FAIL se_rr_grant: got %b want 10", grant); else pass_cnt++;
    tot_cnt++; if (m0_arready !== 1'b0) $display("FAIL se_m0_held: got %b want 0", m0_arready); else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_watchdog();
    do_reset();
    @(negedge clock);
    m0_arvalid = 1; m0_araddr = 32'h2000_0200; m0_rready = 1; s_arready = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 2) begin
        m0_arvalid = 0; s_arready = 0;
      end
      #1;
      tot_cnt++; if (err !== (k >= 8)) $display("FAIL wd_err_cyc%0d: got %b want %b", k, err, (k >= 8)); else pass_cnt++;
      tot_cnt++; if (grant !== 2'b01) $display("FAIL wd_grant_cyc%0d: got %b want 01", k, grant); else pass_cnt++;
    end
    #2;
    reset = 0;
    #1;
    tot_cnt++; if (err !== 1'b0) $display("FAIL wd_async_err: got %b want 0", err); else pass_cnt++;
    tot_cnt++; if (grant !== 2'b00) $display("FAIL wd_async_grant: got %b want 00", grant); else pass_cnt++;
    tot_cnt++; if ({s_arvalid, s_rready, m0_arready} !== 3'b000) $display("FAIL wd_async_hs: got %b want 000", {s_arvalid, s_rready, m0_arready}); else pass_cnt++;
    @(negedge clock);
    reset = 1;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_stall();
    test_wr_then_rd();
    test_slverr();
    test_watchdog();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
